cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined CORDIC core between N_REQ requesters.
// Tracks per-requester credits and routes each result back via a tag pipeline aligned to the core.
module cordic_arbiter #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned WORDLEN  = 16,
    parameter int unsigned N_STAGES = 12,
    parameter int unsigned MAX_OUT  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ-1:0]           req_mode_i,
    input  logic [N_REQ*WORDLEN-1:0]   req_x_i,
    input  logic [N_REQ*WORDLEN-1:0]   req_y_i,
    input  logic [N_REQ*WORDLEN-1:0]   req_z_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       cor_valid_in_o,
    output logic                       cor_mode_o,
    output logic [WORDLEN-1:0]         cor_x_in_o,
    output logic [WORDLEN-1:0]         cor_y_in_o,
    output logic [WORDLEN-1:0]         cor_z_in_o,
    input  logic                       cor_valid_out_i,
    input  logic [WORDLEN-1:0]         cor_x_out_i,
    input  logic [WORDLEN-1:0]         cor_y_out_i,
    input  logic [WORDLEN-1:0]         cor_z_out_i,
    output logic [N_REQ-1:0]           rsp_valid_o,
    output logic [WORDLEN-1:0]         rsp_x_o,
    output logic [WORDLEN-1:0]         rsp_y_o,
    output logic [WORDLEN-1:0]         rsp_z_o,
    output logic                       idle_o,
    output logic                       err_o
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      outst_q [N_REQ];
    logic [CW-1:0]      outst_d [N_REQ];
    logic [N_REQ-1:0]   eligible;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      cand;
    logic               hs;

    logic               sel_mode;
    logic [WORDLEN-1:0] sel_x, sel_y, sel_z;

    logic               cor_valid_q;
    logic               cor_mode_q;
    logic [WORDLEN-1:0] cor_x_q, cor_y_q, cor_z_q;
    logic [IW-1:0]      issue_idx_q;

    logic [N_STAGES-1:0] tag_v_q;
    logic [IW-1:0]       tag_i_q [N_STAGES];

    logic               tail_v;
    logic               fire;
    logic               mismatch;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WORDLEN-1:0] rsp_x_q, rsp_y_q, rsp_z_q;
    logic               err_q;
    logic               cnt_zero;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid_i[i] && en_i && (outst_q[i] < CW'(MAX_OUT));
        end
    end

    // Scan downwards from the farthest offset so the nearest eligible index at/after ptr wins.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        hs        = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (eligible[cand]) begin
                grant_idx = cand;
                hs        = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (hs) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = IW'((int'(grant_idx) + 1) % N_REQ);
        end
    end

    always_comb begin
        sel_mode = 1'b0;
        sel_x    = '0;
        sel_y    = '0;
        sel_z    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_mode = req_mode_i[i];
                sel_x    = req_x_i[i*WORDLEN +: WORDLEN];
                sel_y    = req_y_i[i*WORDLEN +: WORDLEN];
                sel_z    = req_z_i[i*WORDLEN +: WORDLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            cor_valid_q <= 1'b0;
            cor_mode_q  <= 1'b0;
            cor_x_q     <= '0;
            cor_y_q     <= '0;
            cor_z_q     <= '0;
            issue_idx_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cor_valid_q <= hs;
            if (hs) begin
                cor_mode_q  <= sel_mode;
                cor_x_q     <= sel_x;
                cor_y_q     <= sel_y;
                cor_z_q     <= sel_z;
                issue_idx_q <= grant_idx;
            end
        end
    end

    // Tags load from the issue register so the last entry lines up with cor_valid_out_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_v_q <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                tag_i_q[k] <= '0;
            end
        end else begin
            tag_v_q    <= {tag_v_q[N_STAGES-2:0], cor_valid_q};
            tag_i_q[0] <= issue_idx_q;
            for (int k = 1; k < N_STAGES; k++) begin
                tag_i_q[k] <= tag_i_q[k-1];
            end
        end
    end

    assign tail_v   = tag_v_q[N_STAGES-1];
    assign fire     = tail_v && cor_valid_out_i;
    assign mismatch = tail_v ^ cor_valid_out_i;

    always_comb begin
        rsp_valid_d = '0;
        if (fire) begin
            rsp_valid_d[tag_i_q[N_STAGES-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= '0;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_z_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (fire) begin
                rsp_x_q <= cor_x_out_i;
                rsp_y_q <= cor_y_out_i;
                rsp_z_q <= cor_z_out_i;
            end
            if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    // Grant and returned response in the same cycle cancel; saturate at both ends.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outst_d[i] = outst_q[i];
            if (req_ready_o[i] && !rsp_valid_q[i] && (outst_q[i] != CW'(MAX_OUT))) begin
                outst_d[i] = outst_q[i] + CW'(1);
            end else if (rsp_valid_q[i] && !req_ready_o[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    always_comb begin
        cnt_zero = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (outst_q[i] != '0) begin
                cnt_zero = 1'b0;
            end
        end
    end

    assign idle_o         = cnt_zero && (tag_v_q == '0);
    assign err_o          = err_q;
    assign cor_valid_in_o = cor_valid_q;
    assign cor_mode_o     = cor_mode_q;
    assign cor_x_in_o     = cor_x_q;
    assign cor_y_in_o     = cor_y_q;
    assign cor_z_in_o     = cor_z_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_x_o        = rsp_x_q;
    assign rsp_y_o        = rsp_y_q;
    assign rsp_z_o        = rsp_z_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a 12-stage core model: x+0x100, y^0x00FF, z-1.
module tb_cordic_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned W  = 16;
    localparam int unsigned NS = 12;
    localparam int unsigned MO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            en;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_mode;
    logic [W-1:0]    ox [NR];
    logic [W-1:0]    oy [NR];
    logic [W-1:0]    oz [NR];
    logic [NR*W-1:0] req_x, req_y, req_z;
    logic [NR-1:0]   req_ready;
    logic            cor_valid_in, cor_mode;
    logic [W-1:0]    cor_x_in, cor_y_in, cor_z_in;
    logic            cor_valid_out;
    logic [W-1:0]    cor_x_out, cor_y_out, cor_z_out;
    logic [NR-1:0]   rsp_valid;
    logic [W-1:0]    rsp_x, rsp_y, rsp_z;
    logic            idle, err;
    logic            force_vo, kill_vo;

    assign req_x = {ox[2], ox[1], ox[0]};
    assign req_y = {oy[2], oy[1], oy[0]};
    assign req_z = {oz[2], oz[1], oz[0]};

    cordic_arbiter #(
        .N_REQ    (NR),
        .WORDLEN  (W),
        .N_STAGES (NS),
        .MAX_OUT  (MO)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_i            (en),
        .req_valid_i     (req_valid),
        .req_mode_i      (req_mode),
        .req_x_i         (req_x),
        .req_y_i         (req_y),
        .req_z_i         (req_z),
        .req_ready_o     (req_ready),
        .cor_valid_in_o  (cor_valid_in),
        .cor_mode_o      (cor_mode),
        .cor_x_in_o      (cor_x_in),
        .cor_y_in_o      (cor_y_in),
        .cor_z_in_o      (cor_z_in),
        .cor_valid_out_i (cor_valid_out),
        .cor_x_out_i     (cor_x_out),
        .cor_y_out_i     (cor_y_out),
        .cor_z_out_i     (cor_z_out),
        .rsp_valid_o     (rsp_valid),
        .rsp_x_o         (rsp_x),
        .rsp_y_o         (rsp_y),
        .rsp_z_o         (rsp_z),
        .idle_o          (idle),
        .err_o           (err)
    );

    // Core model: fixed NS-cycle latency, shares the arbiter reset.
    logic [NS-1:0]  pv_q;
    logic [3*W-1:0] pd_q [NS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv_q <= '0;
        else        pv_q <= {pv_q[NS-2:0], cor_valid_in};
    end

    always_ff @(posedge clk) begin
        pd_q[0] <= {cor_x_in, cor_y_in, cor_z_in};
        for (int k = 1; k < NS; k++) pd_q[k] <= pd_q[k-1];
    end

    assign cor_valid_out = (pv_q[NS-1] && !kill_vo) || force_vo;
    assign cor_x_out     = pd_q[NS-1][3*W-1:2*W] + 16'h0100;
    assign cor_y_out     = pd_q[NS-1][2*W-1:W] ^ 16'h00FF;
    assign cor_z_out     = pd_q[NS-1][W-1:0] - 16'h0001;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (!idle && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(idle), 32'd1);
    endtask

    int          cnt [NR];
    logic [NR-1:0] seen;
    logic        exp_rdy, exp_rsp;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_mode  = '0;
        force_vo  = 1'b0;
        kill_vo   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ox[i] = '0;
            oy[i] = '0;
            oz[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_val("rst_idle", 32'(idle), 32'd1);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_cor_valid_in", 32'(cor_valid_in), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_rsp_x", 32'(rsp_x), 32'd0);
        rst_n = 1'b1;

        // Single vectoring request from requester 1
        @(negedge clk);
        ox[1] = 16'h1000; oy[1] = 16'h3000; oz[1] = 16'h0000;
        req_mode  = 3'b010;
        req_valid = 3'b010;
        #1 check_val("single_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        check_val("single_issue_v", 32'(cor_valid_in), 32'd1);
        check_val("single_issue_m", 32'(cor_mode), 32'd1);
        check_val("single_issue_x", 32'(cor_x_in), 32'h1000);
        check_val("single_issue_y", 32'(cor_y_in), 32'h3000);
        check_val("single_issue_z", 32'(cor_z_in), 32'h0000);
        repeat (4) @(negedge clk);
        check_val("single_busy", 32'(idle), 32'd0);
        repeat (8) @(negedge clk);
        check_val("single_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_val("single_rsp_v", 32'(rsp_valid), 32'h2);
        check_val("single_rsp_x", 32'(rsp_x), 32'h1100);
        check_val("single_rsp_y", 32'(rsp_y), 32'h30FF);
        check_val("single_rsp_z", 32'(rsp_z), 32'hFFFF);
        @(negedge clk);
        check_val("single_idle", 32'(idle), 32'd1);
        check_val("single_rsp_drop", 32'(rsp_valid), 32'd0);

        // Fairness: all three requesting for nine cycles
        pulse_reset();
        for (int i = 0; i < NR; i++) begin
            ox[i] = 16'(16'h0100 * (i + 1));
            cnt[i] = 0;
        end
        req_valid = 3'b111;
        for (int k = 0; k < 9; k++) begin
            #1 check_val($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
            @(negedge clk);
        end
        req_valid = '0;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < NR; i++) if (rsp_valid[i]) cnt[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < NR; i++) check_val($sformatf("rr_rsp_cnt%0d", i), 32'(cnt[i]), 32'd3);
        check_val("rr_idle", 32'(idle), 32'd1);

        // Credit limit on requester 0
        pulse_reset();
        req_valid = 3'b001;
        for (int k = 0; k < 21; k++) begin
            exp_rdy = (k < 4) || (k >= 15 && k <= 18);
            exp_rsp = (k >= 14 && k <= 17);
            #1;
            check_val($sformatf("credit_ready%0d", k), 32'(req_ready[0]), 32'(exp_rdy));
            check_val($sformatf("credit_rsp%0d", k), 32'(rsp_valid[0]), 32'(exp_rsp));
            @(negedge clk);
        end
        req_valid = '0;
        wait_idle("credit_drain", 40);

        // Enable gating with two operations in flight
        pulse_reset();
        req_valid = 3'b011;
        #1 check_val("en_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1 check_val("en_grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        en = 1'b0;
        #1 check_val("en_blocked", 32'(req_ready), 32'h0);
        repeat (12) @(negedge clk);
        check_val("en_rsp0", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        check_val("en_rsp1", 32'(rsp_valid), 32'h2);
        check_val("en_still_blocked", 32'(req_ready), 32'h0);
        @(negedge clk);
        check_val("en_idle", 32'(idle), 32'd1);
        req_valid = '0;
        en = 1'b1;

        // Spurious core valid with nothing issued
        pulse_reset();
        @(negedge clk);
        force_vo = 1'b1;
        @(negedge clk);
        force_vo = 1'b0;
        check_val("err_set", 32'(err), 32'd1);
        check_val("err_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (5) @(negedge clk);
        check_val("err_sticky", 32'(err), 32'd1);
        check_val("err_idle", 32'(idle), 32'd1);
        pulse_reset();
        check_val("err_cleared", 32'(err), 32'd0);

        // Core drops a result the tag expects
        kill_vo = 1'b1;
        req_valid = 3'b100;
        #1 check_val("miss_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        seen = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 13) check_val("miss_err_before", 32'(err), 32'd0);
            if (k == 14) check_val("miss_err_after", 32'(err), 32'd1);
            seen |= rsp_valid;
            @(negedge clk);
        end
        check_val("miss_no_rsp", 32'(seen), 32'd0);
        kill_vo = 1'b0;
        pulse_reset();

        // Reset five cycles after an issue
        ox[0] = 16'h0ABC;
        req_valid = 3'b001;
        #1 check_val("mid_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        check_val("mid_issue_x", 32'(cor_x_in), 32'h0ABC);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_cvi", 32'(cor_valid_in), 32'd0);
        check_val("mid_rst_cx", 32'(cor_x_in), 32'd0);
        check_val("mid_rst_idle", 32'(idle), 32'd1);
        check_val("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        for (int k = 0; k < 20; k++) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        check_val("mid_no_rsp", 32'(seen), 32'd0);
        check_val("mid_no_err", 32'(err), 32'd0);
        check_val("mid_idle", 32'(idle), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
